btn_debounce: RTL and testbench
===============================

# btn_debounce

Multi-channel push-button debouncer for the VGA controller's user inputs. Each raw asynchronous button line is synchronized into the `clk` domain and filtered by a per-channel stability counter and state machine. The result is a clean, glitch-free registered level that feeds the downstream positive-edge detector's `sig` input. That detector turns each accepted press into a single-cycle pulse.

## Interface
- `N_BTN`, default 4: number of independent button channels, ≥1.
- `DB_CYCLES`, default 250000: consecutive stable `clk` cycles required to accept a change (10 ms at 25 MHz); must be ≥2.
- `SYNC_STAGES`, default 2: flip-flops in each input synchronizer; must be ≥2.
- `clk`  input  1  system/pixel clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn_raw`  input  N_BTN  raw button levels, asynchronous to `clk`, active-high (1 = pressed).
- `btn_db`  output  N_BTN  debounced level per channel; drives the edge detector's `sig`.
- `btn_busy`  output  N_BTN  1 while that channel has a candidate change under qualification.

## Operation
- Synchronizer:
  - Each `btn_raw[i]` passes through a `SYNC_STAGES`-deep flop chain.
  - The last stage is `s[i]`.
  - Only `s[i]` is used by the filter.
- One FSM and one counter per channel; channels are fully independent.
- Counter width is `$clog2(DB_CYCLES+1)` and the counter never wraps.
- FSM states and transitions:
  - S_LOW: `btn_db`=0, `busy`=0. If `s`=1, go to S_RISE with `cnt`=1; otherwise stay.
  - S_RISE: `btn_db`=0, `busy`=1.
    - If `s`=0, return to S_LOW and clear `cnt` (glitch rejected).
    - Else if `cnt`==DB_CYCLES-1, go to S_HIGH, set `btn_db`=1 and clear `cnt`.
    - Else increment `cnt`.
  - S_HIGH: `btn_db`=1, `busy`=0. If `s`=0, go to S_FALL with `cnt`=1.
  - S_FALL: mirror of S_RISE.
    - If `s`=1, return to S_HIGH and clear `cnt`.
    - On `cnt`==DB_CYCLES-1 with `s`=0, go to S_LOW and set `btn_db`=0.
- An accepted change therefore needs `s` at the new value for exactly DB_CYCLES consecutive cycles.
- A single sample back at the old value restarts qualification from zero. No partial credit carries over.
- `btn_db` and `btn_busy` are decoded from registered state only; there is no combinational path from `btn_raw`.
- Reset (`rst_n`=0, asynchronous):
  - All synchronizer flops go to 0.
  - All FSMs go to S_LOW and all counters go to 0.
  - `btn_db`=0 and `btn_busy`=0 immediately, without waiting for `clk`.
- Reset asserted mid-qualification discards the pending change.
- A button held pressed through reset release is re-qualified from S_LOW like a fresh press.

## Timing
- Change of `btn_raw` is first sampled at edge 0 and then held stable:
  - `s` changes after edge SYNC_STAGES-1.
  - FSM enters S_RISE/S_FALL at edge SYNC_STAGES, and `busy` rises at that edge.
  - `btn_db` changes at edge SYNC_STAGES+DB_CYCLES-1.
  - `busy` falls at that same edge.
- Total latency from first sampling to `btn_db` change is SYNC_STAGES+DB_CYCLES-1 cycles.
- Any pulse on `s` shorter than DB_CYCLES cycles never reaches `btn_db`.
- Flip-flops: N_BTN·(SYNC_STAGES+2+$clog2(DB_CYCLES+1)).
- Downstream edge-detector pulse appears one cycle after `btn_db` rises.

## Test plan
Bench parameters: N_BTN=2, DB_CYCLES=8, SYNC_STAGES=2.
- Reset, then `btn_raw`=00 for 20 cycles → `btn_db`=00 and `btn_busy`=00 throughout. Asserting `rst_n`=0 between edges forces outputs to 0 before the next `clk` edge.
- Clean press: `btn_raw[0]` 0→1 sampled at edge 0, held → `btn_busy[0]`=1 from edge 2. `btn_db[0]`=1 at edge 9 and `busy` is 0 at edge 9. Channel 1 stays 0.
- Bounce: `btn_raw[0]` toggles 1,0,1,0,1 at 3-cycle spacing, then held 1 → no `btn_db[0]` change during the bounce. `btn_db[0]` rises 9 cycles after the final rising sample.
- Glitch: 1-cycle and 7-cycle high pulses on `btn_raw[1]` → `btn_db[1]` stays 0. `busy[1]` pulses, then returns to 0.
- Release: from `btn_db[0]`=1, `btn_raw[0]`→0 held → `btn_db[0]`=0 after 9 cycles. A 5-cycle low glitch while high leaves `btn_db[0]`=1.
- Reset mid-qualification: assert `rst_n` at cycle 5 of S_RISE with the button held, release 3 cycles later → `btn_db`=0 during reset. After release, `btn_db` rises SYNC_STAGES+DB_CYCLES-1 cycles after the first post-reset sampling edge. Both channels pressed simultaneously qualify independently at the same edge.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel push-button debouncer.
// Per channel: input synchronizer, stability counter and 4-state FSM.
module btn_debounce #(
   parameter int N_BTN       = 4,
   parameter int DB_CYCLES   = 250000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_busy
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   // State bits are {db, busy}: outputs come straight from flops.
   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      S_RISE = 2'b01,
      S_HIGH = 2'b10,
      S_FALL = 2'b11
   } state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      state_t                 state;
      logic [CW-1:0]          cnt;

      // Bring the raw button level into the clk domain.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync <= '0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw[i]};
         end
      end

      assign s = sync[SYNC_STAGES-1];

      // Accept a level change only after DB_CYCLES stable samples.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= S_LOW;
            cnt   <= '0;
         end else begin
            unique case (state)
               S_LOW: begin
                  if (s) begin
                     state <= S_RISE;
                     cnt   <= ONE;
                  end
               end
               S_RISE: begin
                  if (!s) begin
                     state <= S_LOW;
                     cnt   <= '0;
                  end else if (cnt == LAST) begin
                     state <= S_HIGH;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
               S_HIGH: begin
                  if (!s) begin
                     state <= S_FALL;
                     cnt   <= ONE;
                  end
               end
               S_FALL: begin
                  if (s) begin
                     state <= S_HIGH;
                     cnt   <= '0;
                  end else if (cnt == LAST) begin
                     state <= S_LOW;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
            endcase
         end
      end

      assign btn_db[i]   = state[1];
      assign btn_busy[i] = state[0];
   end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and randomized checks of btn_debounce
// against a run-length reference model.
module tb_btn_debounce;

   localparam int N  = 2;
   localparam int DB = 8;
   localparam int SS = 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] btn_raw = 2'b00;
   logic [1:0] btn_db;
   logic [1:0] btn_busy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   btn_debounce #(
      .N_BTN      (N),
      .DB_CYCLES  (DB),
      .SYNC_STAGES(SS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw),
      .btn_db  (btn_db),
      .btn_busy(btn_busy)
   );

   // Reference: the filter sees the raw level from SS edges ago;
   // a level differing from db for DB samples in a row flips db.
   logic [1:0] hist[$];
   int         run[2];
   logic [1:0] m_db;
   logic [1:0] m_busy;

   always @(posedge clk or negedge rst_n) begin : mdl
      logic [1:0] s;
      if (!rst_n) begin
         hist.delete();
         run[0] = 0;
         run[1] = 0;
         m_db   = 2'b00;
         m_busy = 2'b00;
      end else begin
         s = (hist.size() >= SS) ? hist[SS-1] : 2'b00;
         for (int ch = 0; ch < N; ch++) begin
            if (s[ch] != m_db[ch]) begin
               run[ch]++;
               if (run[ch] == DB) begin
                  m_db[ch]   = ~m_db[ch];
                  m_busy[ch] = 1'b0;
                  run[ch]    = 0;
               end else begin
                  m_busy[ch] = 1'b1;
               end
            end else begin
               run[ch]    = 0;
               m_busy[ch] = 1'b0;
            end
         end
         hist.push_front(btn_raw);
         if (hist.size() > SS) void'(hist.pop_back());
      end
   end

   task automatic chk(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_db", btn_db, m_db);
         chk("model_busy", btn_busy, m_busy);
      end
   end

   // Edge k is the k-th posedge after the call (k=0 samples first).
   task automatic qual(input string nm, input logic [1:0] msk,
                       input logic [1:0] tgt, input bit drive);
      logic [1:0] e_db;
      logic [1:0] e_bs;
      if (drive) btn_raw = (btn_raw & ~msk) | (tgt & msk);
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         e_db = (k >= 9) ? (tgt & msk) : (~tgt & msk);
         e_bs = (k >= 2 && k < 9) ? msk : 2'b00;
         chk({nm, "_db"}, btn_db & msk, e_db);
         chk({nm, "_busy"}, btn_busy & msk, e_bs);
      end
   endtask

   initial begin : stim
      logic seen;
      int   rate;

      rst_n   = 1'b0;
      btn_raw = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_db", btn_db, 2'b00);
      chk("rst_busy", btn_busy, 2'b00);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      repeat (20) begin
         @(negedge clk);
         chk("idle_db", btn_db, 2'b00);
         chk("idle_busy", btn_busy, 2'b00);
      end

      qual("press0", 2'b01, 2'b01, 1'b1);
      chk("press0_ch1", {1'b0, btn_db[1]}, 2'b00);

      #2 rst_n = 1'b0;
      #1;
      chk("async_db", btn_db, 2'b00);
      chk("async_busy", btn_busy, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      qual("rearm0", 2'b01, 2'b01, 1'b0);

      qual("release0", 2'b01, 2'b00, 1'b1);

      btn_raw[0] = 1'b1;
      repeat (12) @(negedge clk);
      chk("hold0", btn_db, 2'b01);
      btn_raw[0] = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("lowglitch_db", btn_db, 2'b01);
      end
      btn_raw[0] = 1'b1;
      repeat (15) begin
         @(negedge clk);
         chk("lowglitch_db", btn_db, 2'b01);
      end

      qual("release0b", 2'b01, 2'b00, 1'b1);

      for (int p = 0; p < 4; p++) begin
         btn_raw[0] = !p[0];
         repeat (3) begin
            @(negedge clk);
            chk("bounce_db", btn_db, 2'b00);
         end
      end
      btn_raw[0] = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         chk("bounce_final", {1'b0, btn_db[0]},
             (k >= 9) ? 2'b01 : 2'b00);
      end

      btn_raw[1] = 1'b1;
      @(negedge clk);
      btn_raw[1] = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= btn_busy[1];
         chk("glitch1_db", {1'b0, btn_db[1]}, 2'b00);
      end
      chk("glitch1_seen", {1'b0, seen}, 2'b01);
      chk("glitch1_idle", {1'b0, btn_busy[1]}, 2'b00);

      btn_raw[1] = 1'b1;
      seen = 1'b0;
      repeat (7) begin
         @(negedge clk);
         seen |= btn_busy[1];
         chk("glitch7_db", {1'b0, btn_db[1]}, 2'b00);
      end
      btn_raw[1] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen |= btn_busy[1];
         chk("glitch7_db", {1'b0, btn_db[1]}, 2'b00);
      end
      chk("glitch7_seen", {1'b0, seen}, 2'b01);
      chk("glitch7_idle", {1'b0, btn_busy[1]}, 2'b00);

      btn_raw = 2'b00;
      repeat (15) @(negedge clk);
      chk("quiet_db", btn_db, 2'b00);

      btn_raw = 2'b11;
      repeat (7) @(negedge clk);
      chk("midq_busy", btn_busy, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("midq_rst_db", btn_db, 2'b00);
      chk("midq_rst_busy", btn_busy, 2'b00);
      repeat (3) begin
         @(negedge clk);
         chk("midq_hold_db", btn_db, 2'b00);
      end
      rst_n = 1'b1;
      qual("post_rst", 2'b11, 2'b11, 1'b0);

      rate = 6;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 100 == 0) rate = $urandom_range(2, 14);
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, rate - 1) == 0)
               btn_raw[ch] = ~btn_raw[ch];
         end
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
         end
      end

      repeat (20) @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
